// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
//   Turns the two board pushbuttons into a duty-cycle command for the PWM
//   generator. Each button is synchronised, debounced and auto-repeated
//   while held; every accepted step moves a saturating duty target. The
//   duty value handed to the PWM generator slews toward that target by one
//   LSB every RAMP_DIV cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   pb_inc       increment button (asynchronous, active-high)
//   pb_dec       decrement button (asynchronous, active-high)
//   duty_target  commanded duty
//   duty_out     ramped duty, feeds the PWM generator duty input
//   busy         duty_out has not yet reached duty_target
//   step_pulse   one-cycle strobe, high in the cycle duty_target updates
//   at_max       duty_target == DUTY_MAX
//   at_min       duty_target == 0
module pwm_duty_ctrl #(
    parameter int DUTY_W       = 8,
    parameter int DUTY_MAX     = 100,
    parameter int DUTY_INIT    = 50,
    parameter int STEP         = 10,
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 16,
    parameter int RAMP_DIV     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_inc,
    input  logic              pb_dec,
    output logic [DUTY_W-1:0] duty_target,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              step_pulse,
    output logic              at_max,
    output logic              at_min
);

    // One shared counter serves debounce, hold delay and repeat rate.
    localparam int CNT_MAX_A = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_RATE) ? CNT_MAX_A : REPEAT_RATE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RAMP_W    = $clog2(RAMP_DIV + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        REPEAT   = 2'd3
    } state_t;

    // Synchronisers
    logic inc_meta_q, inc_s_q;
    logic dec_meta_q, dec_s_q;

    // Press sequencer
    state_t           state_q, state_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step;

    // Duty datapath
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] out_q, out_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic              step_pulse_q, step_pulse_d;

    logic              cmd_inc, cmd_dec, cmd_match;
    logic [DUTY_W:0]   sum_inc;

    // Both buttons together cancel to "no command".
    assign cmd_inc   = inc_s_q & ~dec_s_q;
    assign cmd_dec   = dec_s_q & ~inc_s_q;
    assign cmd_match = dir_up_q ? cmd_inc : cmd_dec;

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        step     = 1'b0;
        if (state_q == IDLE) begin
            if (cmd_inc | cmd_dec) begin
                dir_up_d = cmd_inc;
                cnt_d    = '0;
                state_d  = DEBOUNCE;
            end
        end else if (!cmd_match) begin
            // Release, bounce, direction change or both pressed: abort
            // the press without stepping.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DEBOUNCE: begin
                    if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Target stepping, one bit wider so the increment cannot wrap before
    // it is clamped.
    always_comb begin
        sum_inc      = {1'b0, target_q} + (DUTY_W+1)'(STEP);
        target_d     = target_q;
        step_pulse_d = step;
        if (step) begin
            if (dir_up_q) begin
                if (sum_inc > (DUTY_W+1)'(DUTY_MAX)) target_d = DUTY_W'(DUTY_MAX);
                else                                  target_d = sum_inc[DUTY_W-1:0];
            end else begin
                if ({1'b0, target_q} < (DUTY_W+1)'(STEP)) target_d = '0;
                else                                        target_d = target_q - DUTY_W'(STEP);
            end
        end
    end

    // Soft ramp. The divider only runs while out and target differ, and is
    // not disturbed when the target moves mid-ramp. Moving one LSB at a time
    // toward the target can never overshoot it.
    always_comb begin
        out_d      = out_q;
        ramp_cnt_d = ramp_cnt_q;
        if (out_q == target_q) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1)) begin
            ramp_cnt_d = '0;
            if (target_q > out_q) out_d = out_q + DUTY_W'(1);
            else                  out_d = out_q - DUTY_W'(1);
        end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_meta_q   <= 1'b0;
            inc_s_q      <= 1'b0;
            dec_meta_q   <= 1'b0;
            dec_s_q      <= 1'b0;
            state_q      <= IDLE;
            dir_up_q     <= 1'b0;
            cnt_q        <= '0;
            target_q     <= DUTY_W'(DUTY_INIT);
            out_q        <= DUTY_W'(DUTY_INIT);
            ramp_cnt_q   <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            inc_meta_q   <= pb_inc;
            inc_s_q      <= inc_meta_q;
            dec_meta_q   <= pb_dec;
            dec_s_q      <= dec_meta_q;
            state_q      <= state_d;
            dir_up_q     <= dir_up_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            out_q        <= out_d;
            ramp_cnt_q   <= ramp_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign duty_target = target_q;
    assign duty_out    = out_q;
    assign step_pulse  = step_pulse_q;
    assign busy        = (out_q != target_q);
    assign at_max      = (target_q == DUTY_W'(DUTY_MAX));
    assign at_min      = (target_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl at default parameters. A cycle model derived from
// the press/run-length rules drives a per-cycle compare; directed sequences
// pin the model with literal values.
module tb_pwm_duty_ctrl;

    localparam int DUTY_W       = 8;
    localparam int DUTY_MAX     = 100;
    localparam int DUTY_INIT    = 50;
    localparam int STEP         = 10;
    localparam int DB_CYCLES    = 4;
    localparam int REPEAT_DELAY = 32;
    localparam int REPEAT_RATE  = 16;
    localparam int RAMP_DIV     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pb_inc = 1'b0;
    logic              pb_dec = 1'b0;
    logic [DUTY_W-1:0] duty_target, duty_out;
    logic              busy, step_pulse, at_max, at_min;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    logic [DUTY_W-1:0] seen_q[$];
    logic [DUTY_W-1:0] exp_q[$];

    pwm_duty_ctrl #(
        .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX), .DUTY_INIT(DUTY_INIT), .STEP(STEP),
        .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk(clk), .rst(rst), .pb_inc(pb_inc), .pb_dec(pb_dec),
        .duty_target(duty_target), .duty_out(duty_out), .busy(busy),
        .step_pulse(step_pulse), .at_max(at_max), .at_min(at_min)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // A step fires when a command has been seen unchanged for DB+1 edges,
    // again REPEAT_DELAY edges later, then every REPEAT_RATE edges.
    bit m_h1i, m_h2i, m_h1d, m_h2d;
    int m_prev = 0;
    int m_run  = 0;
    int m_u    = 0;
    int m_tgt  = DUTY_INIT;
    int m_out  = DUTY_INIT;
    bit m_pulse = 1'b0;

    task automatic model_step();
        int  c;
        bit  st;
        int  first;
        if (rst) begin
            m_h1i = 0; m_h2i = 0; m_h1d = 0; m_h2d = 0;
            m_prev = 0; m_run = 0; m_u = 0;
            m_tgt = DUTY_INIT; m_out = DUTY_INIT; m_pulse = 0;
            return;
        end
        // Command as seen through two synchroniser stages.
        c = (m_h2i && !m_h2d) ? 1 : ((m_h2d && !m_h2i) ? -1 : 0);
        m_h2i = m_h1i; m_h1i = pb_inc;
        m_h2d = m_h1d; m_h1d = pb_dec;

        // Direct reversal costs one edge in IDLE before the new run starts.
        if (c == 0)              m_run = 0;
        else if (c == m_prev)    m_run = m_run + 1;
        else if (m_prev == 0)    m_run = 1;
        else                     m_run = 0;
        m_prev = c;

        first = DB_CYCLES + 1;
        st = (m_run == first) ||
             (m_run >= first + REPEAT_DELAY &&
              ((m_run - first - REPEAT_DELAY) % REPEAT_RATE) == 0);

        // Ramp: count unequal edges, move every RAMP_DIV-th one.
        if (m_out != m_tgt) begin
            m_u++;
            if (m_u % RAMP_DIV == 0) m_out = (m_tgt > m_out) ? m_out + 1 : m_out - 1;
        end else begin
            m_u = 0;
        end

        if (st) begin
            if (c > 0) m_tgt = (m_tgt + STEP > DUTY_MAX) ? DUTY_MAX : m_tgt + STEP;
            else       m_tgt = (m_tgt < STEP) ? 0 : m_tgt - STEP;
        end
        m_pulse = st;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("cyc_duty_target", duty_target, m_tgt);
            check("cyc_duty_out", duty_out, m_out);
            check("cyc_busy", busy, (m_out != m_tgt));
            check("cyc_step_pulse", step_pulse, m_pulse);
            check("cyc_at_max", at_max, (m_tgt == DUTY_MAX));
            check("cyc_at_min", at_min, (m_tgt == 0));
            if (step_pulse === 1'b1) begin
                pulse_cnt++;
                seen_q.push_back(duty_target);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic press(input logic i, input logic d, input int n);
        pb_inc = i;
        pb_dec = d;
        repeat (n) @(posedge clk);
        #1;
        pb_inc = 1'b0;
        pb_dec = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int sz;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        @(negedge clk);
        check("rst_target", duty_target, 50);
        check("rst_out", duty_out, 50);
        check("rst_busy", busy, 0);
        check("rst_at_max", at_max, 0);
        check("rst_at_min", at_min, 0);
        check("rst_step_pulse", step_pulse, 0);

        // 2: short glitch rejected, then one clean press
        base = pulse_cnt;
        press(1'b1, 1'b0, 2);
        idle(20);
        check("glitch_pulses", pulse_cnt - base, 0);
        check("glitch_target", duty_target, 50);
        base = pulse_cnt;
        press(1'b1, 1'b0, 12);
        idle(5);
        check("single_pulses", pulse_cnt - base, 1);
        check("single_target", duty_target, 60);
        check("single_busy_mid", busy, 1);
        idle(25);
        check("single_out", duty_out, 60);
        check("single_busy_end", busy, 0);

        // 3: hold increment to saturation and beyond
        do_reset();
        idle(5);
        base = pulse_cnt;
        sz = seen_q.size();
        press(1'b1, 1'b0, 400);
        idle(10);
        check("hold_inc_pulses", pulse_cnt - base, 24);
        exp_q = '{8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd100, 8'd100};
        foreach (exp_q[k]) check("hold_inc_seq", seen_q[sz + k], exp_q[k]);
        check("hold_inc_at_max", at_max, 1);
        check("hold_inc_target", duty_target, 100);
        idle(80);
        check("hold_inc_out", duty_out, 100);

        // 4: hold decrement to zero and beyond
        base = pulse_cnt;
        sz = seen_q.size();
        press(1'b0, 1'b1, 220);
        idle(10);
        check("hold_dec_pulses", pulse_cnt - base, 13);
        exp_q = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30,
                  8'd20, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};
        foreach (exp_q[k]) check("hold_dec_seq", seen_q[sz + k], exp_q[k]);
        check("hold_dec_at_min", at_min, 1);
        idle(250);
        check("hold_dec_out", duty_out, 0);
        check("hold_dec_busy", busy, 0);

        // 5: both buttons cancel; releasing one qualifies the other
        base = pulse_cnt;
        pb_inc = 1'b1;
        pb_dec = 1'b1;
        idle(100);
        check("both_pulses", pulse_cnt - base, 0);
        pb_dec = 1'b0;
        idle(20);
        pb_inc = 1'b0;
        idle(5);
        check("both_release_pulses", pulse_cnt - base, 1);
        check("both_release_target", duty_target, 10);

        // 6: asynchronous reset mid-ramp with the button still held
        do_reset();
        idle(3);
        base = pulse_cnt;
        pb_inc = 1'b1;
        for (int k = 0; k < 200 && (pulse_cnt - base) < 3; k++) @(negedge clk);
        check("ramp_pulses_before_rst", pulse_cnt - base, 3);
        check("ramp_target_before_rst", duty_target, 80);
        check("ramp_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_target", duty_target, 50);
        check("async_rst_out", duty_out, 50);
        check("async_rst_busy", busy, 0);
        check("async_rst_pulse", step_pulse, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("requalify_no_early_step", step_pulse, 0);
        check("requalify_target_early", duty_target, 50);
        @(posedge clk);
        #1;
        check("requalify_step_latency", step_pulse, 1);
        check("requalify_target", duty_target, 60);
        pb_inc = 1'b0;
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
